// File: rtl/add_result_stage_if.sv
// Operand/result handshake bundle for add_result_stage.
// master drives operands and consumes results; slave is the adder stage.
interface add_result_stage_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output in_valid, a, b, sat_en, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, a, b, sat_en, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/add_result_stage.sv
// Signed add with optional saturation, buffered in a 2-entry result FIFO; overflow count/sticky.
// Latency 1 cycle from acceptance to out_valid when the buffer is empty.
// in_ready is a flop (low while 2 entries held), never combinational on out_ready.
module add_result_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    add_result_stage_if.slave    bus,
    input  logic                 clr,
    output logic [CNT_W-1:0]     ovf_cnt,
    output logic                 sticky_ovf
);
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             ovf;
    } entry_t;

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] sat_val;
    logic             ovf;
    entry_t           new_entry;

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [1:0] count_nxt;
    logic       in_rdy_q;
    logic       push;
    logic       pop;
    entry_t     head;

    assign raw     = bus.a + bus.b;
    assign ovf     = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (raw[WIDTH-1] != bus.a[WIDTH-1]);
    // Overflow direction follows the operand sign: positive clamps to max, negative to min.
    assign sat_val = bus.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    assign new_entry.sum = (ovf && bus.sat_en) ? sat_val : raw;
    assign new_entry.ovf = ovf;

    assign push = bus.in_valid && in_rdy_q;
    assign pop  = (count != 2'd0) && bus.out_ready;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (!push && pop) begin
            count_nxt = count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            in_rdy_q <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count    <= count_nxt;
            in_rdy_q <= (count_nxt != 2'd2);
        end
    end

    assign head          = mem[rd_ptr];
    assign bus.in_ready  = in_rdy_q;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_sum   = head.sum;
    assign bus.out_ovf   = head.ovf;

    // A clear coinciding with an overflow restarts the count at that overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt    <= '0;
            sticky_ovf <= 1'b0;
        end else if (clr) begin
            ovf_cnt    <= (push && ovf) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            sticky_ovf <= push && ovf;
        end else if (push && ovf) begin
            if (ovf_cnt != {CNT_W{1'b1}}) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
            sticky_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_add_result_stage.sv
// Directed-vector bench for add_result_stage with hand-computed expectations.
module tb_add_result_stage;
    logic       clk;
    logic       rst;
    logic       clr;
    logic [7:0] ovf_cnt;
    logic       sticky_ovf;
    int         n_checks;
    int         n_errs;

    add_result_stage_if #(.WIDTH(8)) bus ();

    add_result_stage #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr        (clr),
        .ovf_cnt    (ovf_cnt),
        .sticky_ovf (sticky_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction into an empty buffer, checked at the head, then popped.
    task automatic xact(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sat, input logic [7:0] exp_sum, input logic exp_ovf,
                        input logic [7:0] exp_cnt);
        bus.a        = av;
        bus.b        = bv;
        bus.sat_en   = sat;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(bus.out_sum), 32'(exp_sum));
        chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(exp_ovf));
        chk({tag, "_cnt"}, 32'(ovf_cnt), 32'(exp_cnt));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_empty"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_errs        = 0;
        rst           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.sat_en    = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum",   32'(bus.out_sum),   32'd0);
        chk("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
        chk("rst_ovf_cnt",   32'(ovf_cnt),       32'd0);
        chk("rst_sticky",    32'(sticky_ovf),    32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        xact("pos_sat",  8'h40, 8'h40, 1'b1, 8'h7F, 1'b1, 8'd1);
        chk("pos_sat_sticky", 32'(sticky_ovf), 32'd1);
        xact("pos_wrap", 8'h40, 8'h40, 1'b0, 8'h80, 1'b1, 8'd2);
        xact("neg_sat",  8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 8'd3);
        xact("no_ovf1",  8'h7F, 8'h81, 1'b1, 8'h00, 1'b0, 8'd3);
        xact("no_ovf2",  8'hFF, 8'hFF, 1'b1, 8'hFE, 1'b0, 8'd3);
        xact("neg_wrap", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'd4);

        // Fill with out_ready low, then drain while a third operand waits.
        bus.sat_en   = 1'b0;
        bus.a        = 8'h01;
        bus.b        = 8'h02;
        bus.in_valid = 1'b1;
        step();
        chk("fill1_in_ready", 32'(bus.in_ready), 32'd1);
        bus.a = 8'h03;
        bus.b = 8'h04;
        step();
        chk("fill2_in_ready", 32'(bus.in_ready), 32'd0);
        chk("fill2_head",     32'(bus.out_sum),  32'h03);
        bus.a = 8'h05;
        bus.b = 8'h06;
        step();
        chk("full_in_ready",  32'(bus.in_ready), 32'd0);
        chk("full_hold_head", 32'(bus.out_sum),  32'h03);
        chk("full_hold_vld",  32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step();
        chk("drain1_in_ready", 32'(bus.in_ready),  32'd1);
        chk("drain1_head",     32'(bus.out_sum),   32'h07);
        step();
        bus.in_valid = 1'b0;
        chk("pushpop_vld",  32'(bus.out_valid), 32'd1);
        chk("pushpop_head", 32'(bus.out_sum),   32'h0B);
        step();
        chk("drain_empty",  32'(bus.out_valid), 32'd0);
        chk("drain_cnt",    32'(ovf_cnt),       32'd4);
        bus.out_ready = 1'b0;

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnt",    32'(ovf_cnt),    32'd0);
        chk("clr_sticky", 32'(sticky_ovf), 32'd0);

        // 300 back-to-back overflows with the consumer always ready.
        bus.out_ready = 1'b1;
        bus.a         = 8'h40;
        bus.b         = 8'h40;
        bus.sat_en    = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        chk("cnt_saturate", 32'(ovf_cnt),    32'hFF);
        chk("cnt_sticky",   32'(sticky_ovf), 32'd1);
        clr = 1'b1;
        step();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_ovf_cnt",    32'(ovf_cnt),    32'd1);
        chk("clr_ovf_sticky", 32'(sticky_ovf), 32'd1);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Reach ovf_cnt=5 with two results buffered, then reset.
        bus.in_valid = 1'b1;
        step();
        step();
        step();
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        chk("pre_rst_cnt",      32'(ovf_cnt),       32'd5);
        chk("pre_rst_in_ready", 32'(bus.in_ready),  32'd0);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        clr           = 1'b1;
        step();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clr           = 1'b0;
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_ovf_cnt",   32'(ovf_cnt),       32'd0);
        chk("rst2_sticky",    32'(sticky_ovf),    32'd0);
        chk("rst2_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst2_out_sum",   32'(bus.out_sum),   32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/add_result_stage.md
ADD_RESULT_STAGE -- requirements
Module: add_result_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the overflow event counter width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  an operand pair is presented.
REQ-006 in_ready  output  1  the stage can accept an operand pair this cycle.
REQ-007 a  input  WIDTH  signed two's-complement operand A.
REQ-008 b  input  WIDTH  signed two's-complement operand B.
REQ-009 sat_en  input  1  saturate on overflow when 1; wrap when 0; sampled at acceptance.
REQ-010 out_valid  output  1  a result is available at the head of the buffer.
REQ-011 out_ready  input  1  the consumer takes the head result this cycle.
REQ-012 out_sum  output  WIDTH  head result sum.
REQ-013 out_ovf  output  1  head result overflowed.
REQ-014 ovf_cnt  output  CNT_W  count of accepted overflowing transactions.
REQ-015 sticky_ovf  output  1  at least one overflow has occurred since the last clear.
REQ-016 clr  input  1  clears ovf_cnt and sticky_ovf.

Function
REQ-017 A transaction SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-018 The raw sum SHALL be the low WIDTH bits of a+b.
REQ-019 The overflow flag ovf SHALL be 1 exactly when a[MSB]==b[MSB] and raw[MSB]!=a[MSB].
REQ-020 When ovf=1 and sat_en=1, the result SHALL be the maximum positive value (0x7F at WIDTH=8) if a[MSB]=0, and the minimum negative value (0x80) if a[MSB]=1.
REQ-021 When ovf=0, or when sat_en=0, the result SHALL be raw; no X or undefined value SHALL ever appear on out_sum.
REQ-022 The {result, ovf} pair SHALL be written into a 2-entry FIFO on acceptance.
REQ-023 Latency SHALL be 1 cycle: with the FIFO empty, out_valid=1 on the cycle after acceptance.
REQ-024 in_ready SHALL be 1 iff the FIFO holds fewer than 2 entries, is registered, and SHALL not depend combinationally on out_ready.
REQ-025 out_valid SHALL be 1 iff the FIFO is non-empty; out_sum and out_ovf SHALL show the oldest entry.
REQ-026 The head SHALL be popped on a rising edge where out_valid and out_ready are both 1.
REQ-027 Simultaneous push and pop with 1 entry held: the occupancy SHALL stay 1 and the new entry SHALL become the head.
REQ-028 With 2 entries held, no push SHALL occur even if a pop happens in the same cycle; in_ready SHALL return to 1 on the following cycle.
REQ-029 While out_valid=1 and out_ready=0, out_sum and out_ovf SHALL hold stable.
REQ-030 ovf_cnt SHALL increment by 1 per accepted transaction with ovf=1, and SHALL saturate at all-ones without wrapping.
REQ-031 sticky_ovf SHALL set on any accepted transaction with ovf=1.
REQ-032 clr=1 SHALL zero ovf_cnt and sticky_ovf on the next edge.
REQ-033 If clr coincides with an accepted overflowing transaction, then ovf_cnt SHALL be 1 and sticky_ovf SHALL be 1 after the edge.
REQ-034 Counter and sticky updates SHALL happen at acceptance, independent of when the result is popped.

Reset
REQ-035 While rst=1 at an edge, the FIFO SHALL be emptied, out_valid, out_sum, out_ovf, ovf_cnt and sticky_ovf SHALL be 0, and in_ready SHALL be 1 after the edge.
REQ-036 Reset SHALL override any simultaneous push, pop or clr, and entries buffered before reset SHALL be discarded.

Verification
REQ-037 a=0x40, b=0x40, sat_en=1 -> out_sum=0x7F, out_ovf=1 one cycle later; ovf_cnt=1, sticky_ovf=1.
REQ-038 a=0x40, b=0x40, sat_en=0 -> out_sum=0x80, out_ovf=1; a=0x80, b=0xFF, sat_en=1 -> out_sum=0x80, out_ovf=1.
REQ-039 a=0x7F, b=0x81 -> out_sum=0x00, out_ovf=0; a=0xFF, b=0xFF -> out_sum=0xFE, out_ovf=0; ovf_cnt unchanged in both cases.
REQ-040 Hold out_ready=0 and push 3 pairs -> in_ready=0 after 2 are accepted; release out_ready -> results come out in order, with no loss or duplication.
REQ-041 Run 300 overflowing transactions with CNT_W=8 -> ovf_cnt=255; pulse clr together with one more overflow -> ovf_cnt=1.
REQ-042 Assert rst with 2 entries buffered and ovf_cnt=5 -> next cycle out_valid=0, ovf_cnt=0, sticky_ovf=0, in_ready=1.
